wdt_reset_ctrl: RTL and testbench

Generates the core reset sequence and watchdog supervision for the PIC16C57 core, directly upstream of the data RAM/register-file stage. It produces that stage's reset qualifier and cause flags: core reset, POR, MCLR_rst and WDT_timeout. It also produces the STATUS TO/PD load/set strobes for CLRWDT and SLEEP, plus the sleep hold. It contains the WDT base counter, the 8-bit prescaler (WDT assignment only), the MCLR synchroniser and the reset-hold sequencer.

---
 rtl/wdt_reset_pkg.sv | 28 ++
 rtl/wdt_reset_ctrl_mclr_sync.sv | 56 +++++
 rtl/wdt_reset_ctrl.sv | 163 ++++++++++++++++
 tb/tb_wdt_reset_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_reset_pkg.sv
// Shared types and constants for the PIC16C57 reset/watchdog controller.
// State and reset-cause encodings, default sizes and the prescaler mask helper.
package wdt_reset_pkg;

    localparam int WDT_BASE_W_DEF = 8;
    localparam int RST_HOLD_DEF   = 4;
    localparam int MCLR_FILT_DEF  = 3;
    localparam int PRE_W          = 8;
    localparam int PS_W           = 3;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_SLEEP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR,
        CAUSE_MCLR,
        CAUSE_WDT
    } cause_e;

    // Prescaler bits that must all be set for a tick to become a timeout.
    function automatic logic [PRE_W-1:0] ps_mask(input logic [PS_W-1:0] ps);
        return (PRE_W'(1) << ps) - PRE_W'(1);
    endfunction

endpackage

// File: rtl/wdt_reset_ctrl_mclr_sync.sv
// MCLR pin synchroniser with an optional low-pulse glitch filter.
// Build option: define MCLR_GLITCH_FILTER_EN to require MCLR_FILT consecutive low samples.
module wdt_reset_ctrl_mclr_sync
    import wdt_reset_pkg::*;
#(
    parameter int MCLR_FILT = MCLR_FILT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mclr_n_i,
    output logic mclr_sync_o
);

`ifdef MCLR_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif
    localparam int FILT_LEN = (FILT_ON && (MCLR_FILT > 1)) ? MCLR_FILT : 1;

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= mclr_n_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (FILT_LEN > 1) begin : g_filt
            localparam int CW = $clog2(FILT_LEN + 1);
            logic [CW-1:0] low_cnt_q;

            // Counts earlier consecutive low samples; the current low sample completes the run.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    low_cnt_q <= '0;
                end else if (sync2_q) begin
                    low_cnt_q <= '0;
                end else if (low_cnt_q != CW'(FILT_LEN)) begin
                    low_cnt_q <= low_cnt_q + CW'(1);
                end
            end

            assign mclr_sync_o = !sync2_q && (low_cnt_q >= CW'(FILT_LEN - 1));
        end else begin : g_pass
            assign mclr_sync_o = !sync2_q;
        end
    endgenerate

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Core reset sequencer and watchdog for the PIC16C57: reset causes, TO/PD strobes, sleep hold.
// Build option: MCLR_GLITCH_FILTER_EN enables the MCLR glitch filter in the synchroniser.
module wdt_reset_ctrl
    import wdt_reset_pkg::*;
#(
    parameter int WDT_BASE_W = WDT_BASE_W_DEF,
    parameter int RST_HOLD   = RST_HOLD_DEF,
    parameter int MCLR_FILT  = MCLR_FILT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mclr_n,
    input  logic            wdt_en,
    input  logic            clrwdt,
    input  logic            sleep_inst,
    input  logic            psa,
    input  logic [PS_W-1:0] ps,
    output logic            core_rst_n,
    output logic            por,
    output logic            mclr_rst,
    output logic            wdt_timeout,
    output logic            load_to,
    output logic            set_to,
    output logic            load_pd,
    output logic            set_pd,
    output logic            sleeping
);

    localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

    state_e                  state_q;
    logic [HOLD_W-1:0]       hold_q;
    logic [WDT_BASE_W-1:0]   base_q;
    logic [PRE_W-1:0]        pre_q;
    logic                    core_rst_n_q;
    logic                    por_q;
    logic                    mclr_rst_q;
    logic                    wdt_timeout_q;
    logic                    load_to_q;
    logic                    set_to_q;
    logic                    load_pd_q;
    logic                    set_pd_q;
    logic                    sleeping_q;

    logic                    mclr_sync;
    logic                    wdt_tick;
    logic                    pre_hit;
    logic                    wdt_expire;
    logic                    run_clear;
    logic                    rst_req;
    cause_e                  rst_cause;

    wdt_reset_ctrl_mclr_sync #(
        .MCLR_FILT (MCLR_FILT)
    ) u_mclr_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .mclr_n_i    (mclr_n),
        .mclr_sync_o (mclr_sync)
    );

    assign wdt_tick   = wdt_en && (base_q == '1);
    assign pre_hit    = ((pre_q & ps_mask(ps)) == ps_mask(ps));
    assign wdt_expire = wdt_tick && (!psa || pre_hit);
    // CLRWDT/SLEEP in RUN clear the counters, so they swallow a coincident timeout.
    assign run_clear  = (state_q == ST_RUN) && (sleep_inst || clrwdt);
    assign rst_req    = mclr_sync || (wdt_expire && !run_clear);
    assign rst_cause  = mclr_sync ? CAUSE_MCLR : CAUSE_WDT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RESET;
            hold_q        <= HOLD_INIT;
            base_q        <= '0;
            pre_q         <= '0;
            core_rst_n_q  <= 1'b0;
            por_q         <= 1'b1;
            mclr_rst_q    <= 1'b0;
            wdt_timeout_q <= 1'b0;
            load_to_q     <= 1'b0;
            set_to_q      <= 1'b0;
            load_pd_q     <= 1'b0;
            set_pd_q      <= 1'b0;
            sleeping_q    <= 1'b0;
        end else begin
            load_to_q <= 1'b0;
            set_to_q  <= 1'b0;
            load_pd_q <= 1'b0;
            set_pd_q  <= 1'b0;
            case (state_q)
                ST_RESET: begin
                    base_q <= '0;
                    pre_q  <= '0;
                    if (mclr_sync) begin
                        hold_q <= HOLD_INIT;
                    end else if ((hold_q == HOLD_W'(1)) || (hold_q == '0)) begin
                        hold_q        <= '0;
                        state_q       <= ST_RUN;
                        core_rst_n_q  <= 1'b1;
                        por_q         <= 1'b0;
                        mclr_rst_q    <= 1'b0;
                        wdt_timeout_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                ST_RUN, ST_SLEEP: begin
                    if (rst_req) begin
                        state_q       <= ST_RESET;
                        hold_q        <= HOLD_INIT;
                        base_q        <= '0;
                        pre_q         <= '0;
                        core_rst_n_q  <= 1'b0;
                        sleeping_q    <= 1'b0;
                        por_q         <= (rst_cause == CAUSE_POR);
                        mclr_rst_q    <= (rst_cause == CAUSE_MCLR);
                        wdt_timeout_q <= (rst_cause == CAUSE_WDT);
                    end else if ((state_q == ST_RUN) && sleep_inst) begin
                        state_q    <= ST_SLEEP;
                        base_q     <= '0;
                        pre_q      <= '0;
                        sleeping_q <= 1'b1;
                        load_to_q  <= 1'b1;
                        set_to_q   <= 1'b1;
                        load_pd_q  <= 1'b1;
                    end else if ((state_q == ST_RUN) && clrwdt) begin
                        base_q    <= '0;
                        pre_q     <= '0;
                        load_to_q <= 1'b1;
                        set_to_q  <= 1'b1;
                        load_pd_q <= 1'b1;
                        set_pd_q  <= 1'b1;
                    end else begin
                        if (wdt_en) begin
                            base_q <= base_q + WDT_BASE_W'(1);
                        end
                        if (wdt_tick && psa) begin
                            pre_q <= pre_q + PRE_W'(1);
                        end
                    end
                end
                default: begin
                    state_q      <= ST_RESET;
                    hold_q       <= HOLD_INIT;
                    core_rst_n_q <= 1'b0;
                    sleeping_q   <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign por         = por_q;
    assign mclr_rst    = mclr_rst_q;
    assign wdt_timeout = wdt_timeout_q;
    assign load_to     = load_to_q;
    assign set_to      = set_to_q;
    assign load_pd     = load_pd_q;
    assign set_pd      = set_pd_q;
    assign sleeping    = sleeping_q;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Scoreboard bench for wdt_reset_ctrl: per-cycle stimulus and expected outputs are queued,
// then replayed one clock at a time and compared just after each rising edge.
module tb_wdt_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mclr_n = 1'b1;
    logic       wdt_en = 1'b0;
    logic       clrwdt = 1'b0;
    logic       sleep_inst = 1'b0;
    logic       psa = 1'b0;
    logic [2:0] ps = 3'd0;
    logic       core_rst_n, por, mclr_rst, wdt_timeout;
    logic       load_to, set_to, load_pd, set_pd, sleeping;
    logic [8:0] outv;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] stim_q[$];
    logic [8:0] exp_q[$];
    string      tag_q[$];

    // {core_rst_n, por, mclr_rst, wdt_timeout, load_to, set_to, load_pd, set_pd, sleeping}
    localparam logic [8:0] V_POR   = 9'b0_100_0000_0;
    localparam logic [8:0] V_IDLE  = 9'b1_000_0000_0;
    localparam logic [8:0] V_CLR   = 9'b1_000_1111_0;
    localparam logic [8:0] V_SLP   = 9'b1_000_1110_1;
    localparam logic [8:0] V_SLEEP = 9'b1_000_0000_1;
    localparam logic [8:0] V_WDT   = 9'b0_001_0000_0;
    localparam logic [8:0] V_MCLR  = 9'b0_010_0000_0;
`ifdef MCLR_GLITCH_FILTER_EN
    localparam int FD = 2;
`else
    localparam int FD = 0;
`endif

    wdt_reset_ctrl #(
        .WDT_BASE_W (4),
        .RST_HOLD   (4),
        .MCLR_FILT  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mclr_n      (mclr_n),
        .wdt_en      (wdt_en),
        .clrwdt      (clrwdt),
        .sleep_inst  (sleep_inst),
        .psa         (psa),
        .ps          (ps),
        .core_rst_n  (core_rst_n),
        .por         (por),
        .mclr_rst    (mclr_rst),
        .wdt_timeout (wdt_timeout),
        .load_to     (load_to),
        .set_to      (set_to),
        .load_pd     (load_pd),
        .set_pd      (set_pd),
        .sleeping    (sleeping)
    );

    assign outv = {core_rst_n, por, mclr_rst, wdt_timeout, load_to, set_to, load_pd, set_pd, sleeping};

    always #5 clk = ~clk;

    // Queue n cycles of {rst_n, mclr_n, clrwdt, sleep_inst} with the output expected after that edge.
    task automatic sched(input int n, input logic r, input logic m, input logic c, input logic s,
                         input logic [8:0] e, input string tag);
        for (int i = 0; i < n; i++) begin
            stim_q.push_back({r, m, c, s});
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    task automatic preamble();
        sched(1, 1'b0, 1'b1, 1'b0, 1'b0, V_POR, "por_enter");
        sched(3, 1'b1, 1'b1, 1'b0, 1'b0, V_POR, "por_hold");
    endtask

    task automatic test_reset();
        logic [8:0] e;
        string tg;
        wdt_en = 1'b0;
        sched(3, 1'b0, 1'b1, 1'b0, 1'b0, V_POR, "reset_low");
        sched(3, 1'b1, 1'b1, 1'b0, 1'b0, V_POR, "reset_hold");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "reset_release");
        while (exp_q.size() != 0) begin
            {rst_n, mclr_n, clrwdt, sleep_inst} = stim_q.pop_front();
            @(posedge clk); #1;
            e = exp_q.pop_front(); tg = tag_q.pop_front(); cyc++; checks++;
            if (outv !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tg, cyc, outv, e);
            end
        end
        $display("test_reset done cyc=%0d", cyc);
    endtask

    task automatic test_wdt_1to1();
        logic [8:0] e;
        string tg;
        wdt_en = 1'b1; psa = 1'b0; ps = 3'd0;
        preamble();
        sched(16, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "wdt_run");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_WDT, "wdt_timeout");
        sched(2, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "wdt_rerun");
        while (exp_q.size() != 0) begin
            {rst_n, mclr_n, clrwdt, sleep_inst} = stim_q.pop_front();
            @(posedge clk); #1;
            e = exp_q.pop_front(); tg = tag_q.pop_front(); cyc++; checks++;
            if (outv !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tg, cyc, outv, e);
            end
        end
        $display("test_wdt_1to1 done cyc=%0d", cyc);
    endtask

    task automatic test_prescaler();
        logic [8:0] e;
        string tg;
        wdt_en = 1'b1; psa = 1'b1; ps = 3'd3;
        preamble();
        sched(128, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "pre_run");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_WDT, "pre_timeout");
        sched(100, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "pre_run2");
        sched(1, 1'b1, 1'b1, 1'b1, 1'b0, V_CLR, "pre_clrwdt_pulse");
        sched(127, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "pre_after_clr");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_WDT, "pre_timeout2");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "pre_rerun");
        while (exp_q.size() != 0) begin
            {rst_n, mclr_n, clrwdt, sleep_inst} = stim_q.pop_front();
            @(posedge clk); #1;
            e = exp_q.pop_front(); tg = tag_q.pop_front(); cyc++; checks++;
            if (outv !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tg, cyc, outv, e);
            end
        end
        $display("test_prescaler done cyc=%0d", cyc);
    endtask

    task automatic test_sleep();
        logic [8:0] e;
        string tg;
        wdt_en = 1'b1; psa = 1'b0; ps = 3'd0;
        preamble();
        sched(5, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "slp_run");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b1, V_SLP, "slp_pulse");
        sched(3, 1'b1, 1'b1, 1'b0, 1'b0, V_SLEEP, "slp_hold");
        sched(1, 1'b1, 1'b1, 1'b1, 1'b0, V_SLEEP, "slp_clr_ignored");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b1, V_SLEEP, "slp_sleep_ignored");
        sched(10, 1'b1, 1'b1, 1'b0, 1'b0, V_SLEEP, "slp_hold2");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_WDT, "slp_wdt_wake");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "slp_rerun");
        while (exp_q.size() != 0) begin
            {rst_n, mclr_n, clrwdt, sleep_inst} = stim_q.pop_front();
            @(posedge clk); #1;
            e = exp_q.pop_front(); tg = tag_q.pop_front(); cyc++; checks++;
            if (outv !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tg, cyc, outv, e);
            end
        end
        $display("test_sleep done cyc=%0d", cyc);
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        string tg;
        wdt_en = 1'b1; psa = 1'b0; ps = 3'd0;
        preamble();
        sched(16, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "b2b_run");
        sched(2, 1'b1, 1'b1, 1'b1, 1'b0, V_CLR, "b2b_clr_beats_timeout");
        sched(15, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "b2b_after_clr");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_WDT, "b2b_timeout");
        sched(16, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "b2b_run2");
        sched(1, 1'b1, 1'b1, 1'b1, 1'b1, V_SLP, "b2b_sleep_beats_clr");
        sched(15, 1'b1, 1'b1, 1'b0, 1'b0, V_SLEEP, "b2b_sleep_hold");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_WDT, "b2b_sleep_timeout");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "b2b_rerun");
        while (exp_q.size() != 0) begin
            {rst_n, mclr_n, clrwdt, sleep_inst} = stim_q.pop_front();
            @(posedge clk); #1;
            e = exp_q.pop_front(); tg = tag_q.pop_front(); cyc++; checks++;
            if (outv !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tg, cyc, outv, e);
            end
        end
        $display("test_back_to_back done cyc=%0d", cyc);
    endtask

    task automatic test_mclr();
        logic [8:0] e;
        string tg;
        int j;
        int last;
        wdt_en = 1'b0; psa = 1'b0; ps = 3'd0;
        preamble();
        sched(5, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "mclr_run");
        sched(2 + FD, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE, "mclr_sync_delay");
        sched(8 - FD, 1'b1, 1'b0, 1'b0, 1'b0, V_MCLR, "mclr_asserted");
        sched(5, 1'b1, 1'b1, 1'b0, 1'b0, V_MCLR, "mclr_release_hold");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "mclr_rerun");
        // MCLR becomes visible in the same cycle the WDT ticks out.
        wdt_en = 1'b1;
        preamble();
        j = 15 - FD;
        last = 18 - FD;
        for (int i = 1; i <= last + 5; i++) begin
            sched(1, 1'b1, !((i >= j) && (i <= j + 2)), 1'b0, 1'b0,
                  (i <= 16) ? V_IDLE : ((i <= last + 4) ? V_MCLR : V_IDLE), "mclr_vs_wdt");
        end
        while (exp_q.size() != 0) begin
            {rst_n, mclr_n, clrwdt, sleep_inst} = stim_q.pop_front();
            @(posedge clk); #1;
            e = exp_q.pop_front(); tg = tag_q.pop_front(); cyc++; checks++;
            if (outv !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tg, cyc, outv, e);
            end
        end
        $display("test_mclr done cyc=%0d", cyc);
    endtask

    task automatic test_filter();
        logic [8:0] e;
        string tg;
        wdt_en = 1'b0; psa = 1'b0; ps = 3'd0;
        preamble();
        sched(3, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "filt_run");
`ifdef MCLR_GLITCH_FILTER_EN
        sched(2, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE, "filt_glitch_low");
        sched(8, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "filt_glitch_ignored");
        sched(3, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE, "filt_pulse_low");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "filt_pulse_delay");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_MCLR, "filt_pulse_reset");
`else
        sched(1, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE, "nofilt_glitch_low");
        sched(1, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "nofilt_sync_delay");
        sched(4, 1'b1, 1'b1, 1'b0, 1'b0, V_MCLR, "nofilt_glitch_reset");
`endif
        sched(1, 1'b1, 1'b1, 1'b0, 1'b0, V_IDLE, "filt_rerun");
        while (exp_q.size() != 0) begin
            {rst_n, mclr_n, clrwdt, sleep_inst} = stim_q.pop_front();
            @(posedge clk); #1;
            e = exp_q.pop_front(); tg = tag_q.pop_front(); cyc++; checks++;
            if (outv !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tg, cyc, outv, e);
            end
        end
        $display("test_filter done cyc=%0d", cyc);
    endtask

    initial begin
        test_reset();
        test_wdt_1to1();
        test_prescaler();
        test_sleep();
        test_back_to_back();
        test_mclr();
        test_filter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
